// File: rtl/regfile_wb_arbiter_pkg.sv
// Purpose : shared types and constants for the register-file writeback arbiter.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package regfile_wb_arbiter_pkg;

    localparam int DEF_DATA_WIDTH   = 32;
    localparam int DEF_ADDR_WIDTH   = 8;
    localparam int DEF_STARVE_LIMIT = 3;

    // Counter width that covers the full 1..15 starve limit range.
    localparam int STARVE_CNT_WIDTH = 4;

    // Architectural zero register index.
    localparam int REG_ZERO = 0;

    localparam logic [15:0] CONFLICT_MAX = 16'hFFFF;

    // Writeback request at the default widths.
    typedef struct packed {
        logic [DEF_ADDR_WIDTH-1:0] addr;
        logic [DEF_DATA_WIDTH-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_starve_counter.sv
// Purpose : counts consecutive src1 losses under contention; flags when src1 must be forced to win.
// Latency : force_src1 is combinational from the registered count.
// Backpressure: none; updates every cycle.
// Ports   : clk, reset (sync active-low), contend (both sources eligible),
//           src1_win (src1 granted this cycle), force_src1 (count reached limit).
import regfile_wb_arbiter_pkg::*;

module wb_starve_counter #(
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic clk,
    input  logic reset,
    input  logic contend,
    input  logic src1_win,
    output logic force_src1
);

    localparam logic [STARVE_CNT_WIDTH-1:0] LIMIT = STARVE_CNT_WIDTH'(STARVE_LIMIT);

    logic [STARVE_CNT_WIDTH-1:0] count;

    assign force_src1 = (count == LIMIT);

    // A forced cycle is always a src1 win, so the clear branch covers it and
    // the count never passes LIMIT.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (src1_win) begin
            count <= '0;
        end else if (contend && !force_src1) begin
            count <= count + STARVE_CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Purpose : arbitrates ALU (src0) and load (src1) writebacks onto the single register-file write port,
//           fixed src0 priority with src1 starvation protection, plus read-stage bypass hits.
// Latency : 1 cycle from grant to write_out; ready is combinational.
// Backpressure: sources see ready=0 when they lose; the register file never stalls.
// Ports   : src0_*/src1_* request handshakes, write_* register-file write port,
//           read_addr*_in / bypass*_out forwarding, conflict_cnt_out + debugen_in debug counter.
import regfile_wb_arbiter_pkg::*;

module regfile_wb_arbiter #(
    parameter int DATA_WIDTH       = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH       = DEF_ADDR_WIDTH,
    parameter int STARVE_LIMIT     = DEF_STARVE_LIMIT,
    parameter int ZERO_REG_DISCARD = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  src0_valid_in,
    input  logic [ADDR_WIDTH-1:0] src0_addr_in,
    input  logic [DATA_WIDTH-1:0] src0_data_in,
    output logic                  src0_ready_out,
    input  logic                  src1_valid_in,
    input  logic [ADDR_WIDTH-1:0] src1_addr_in,
    input  logic [DATA_WIDTH-1:0] src1_data_in,
    output logic                  src1_ready_out,
    output logic                  write_out,
    output logic [ADDR_WIDTH-1:0] write_addr_out,
    output logic [DATA_WIDTH-1:0] write_data_out,
    input  logic [ADDR_WIDTH-1:0] read_addr0_in,
    input  logic [ADDR_WIDTH-1:0] read_addr1_in,
    output logic                  bypass0_hit_out,
    output logic                  bypass1_hit_out,
    output logic [DATA_WIDTH-1:0] bypass_data_out,
    output logic [15:0]           conflict_cnt_out,
    input  logic                  debugen_in
);

    localparam bit                    DISCARD_ZERO = (ZERO_REG_DISCARD != 0);
    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR    = ADDR_WIDTH'(REG_ZERO);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } req_t;

    logic src0_is_zero, src1_is_zero;
    logic src0_discard, src1_discard;
    logic src0_elig, src1_elig;
    logic contend, force_src1;
    logic grant0, grant1;
    req_t win_req;

    assign src0_is_zero = (src0_addr_in == ZERO_ADDR);
    assign src1_is_zero = (src1_addr_in == ZERO_ADDR);

    // Zero-register writes are swallowed at the handshake and never reach
    // arbitration, so they neither contend nor move the starve counter.
    assign src0_discard = DISCARD_ZERO && src0_valid_in && src0_is_zero;
    assign src1_discard = DISCARD_ZERO && src1_valid_in && src1_is_zero;
    assign src0_elig    = src0_valid_in && !(DISCARD_ZERO && src0_is_zero);
    assign src1_elig    = src1_valid_in && !(DISCARD_ZERO && src1_is_zero);
    assign contend      = src0_elig && src1_elig;

    assign grant0 = reset && src0_elig && (!src1_elig || !force_src1);
    assign grant1 = reset && src1_elig && (!src0_elig || force_src1);

    assign src0_ready_out = grant0 || (reset && src0_discard);
    assign src1_ready_out = grant1 || (reset && src1_discard);

    wb_starve_counter #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk        (clk),
        .reset      (reset),
        .contend    (contend),
        .src1_win   (grant1),
        .force_src1 (force_src1)
    );

    always_comb begin
        win_req = '{addr: src0_addr_in, data: src0_data_in};
        if (grant1) begin
            win_req = '{addr: src1_addr_in, data: src1_data_in};
        end
    end

    // Address/data hold when idle so the bypass compare stays quiet via write_out.
    always_ff @(posedge clk) begin
        if (!reset) begin
            write_out      <= 1'b0;
            write_addr_out <= '0;
            write_data_out <= '0;
        end else if (grant0 || grant1) begin
            write_out      <= 1'b1;
            write_addr_out <= win_req.addr;
            write_data_out <= win_req.data;
        end else begin
            write_out      <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            conflict_cnt_out <= '0;
        end else if (contend && debugen_in && (conflict_cnt_out != CONFLICT_MAX)) begin
            conflict_cnt_out <= conflict_cnt_out + 16'd1;
        end
    end

    logic write_is_zero;
    assign write_is_zero = DISCARD_ZERO && (write_addr_out == ZERO_ADDR);

    assign bypass0_hit_out = write_out && (read_addr0_in == write_addr_out) && !write_is_zero;
    assign bypass1_hit_out = write_out && (read_addr1_in == write_addr_out) && !write_is_zero;
    assign bypass_data_out = write_data_out;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        src0_valid_in, src1_valid_in;
    logic [7:0]  src0_addr_in, src1_addr_in;
    logic [31:0] src0_data_in, src1_data_in;
    logic        src0_ready_out, src1_ready_out;
    logic        write_out;
    logic [7:0]  write_addr_out;
    logic [31:0] write_data_out;
    logic [7:0]  read_addr0_in, read_addr1_in;
    logic        bypass0_hit_out, bypass1_hit_out;
    logic [31:0] bypass_data_out;
    logic [15:0] conflict_cnt_out;
    logic        debugen_in;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(
        .DATA_WIDTH       (32),
        .ADDR_WIDTH       (8),
        .STARVE_LIMIT     (3),
        .ZERO_REG_DISCARD (1)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .src0_valid_in    (src0_valid_in),
        .src0_addr_in     (src0_addr_in),
        .src0_data_in     (src0_data_in),
        .src0_ready_out   (src0_ready_out),
        .src1_valid_in    (src1_valid_in),
        .src1_addr_in     (src1_addr_in),
        .src1_data_in     (src1_data_in),
        .src1_ready_out   (src1_ready_out),
        .write_out        (write_out),
        .write_addr_out   (write_addr_out),
        .write_data_out   (write_data_out),
        .read_addr0_in    (read_addr0_in),
        .read_addr1_in    (read_addr1_in),
        .bypass0_hit_out  (bypass0_hit_out),
        .bypass1_hit_out  (bypass1_hit_out),
        .bypass_data_out  (bypass_data_out),
        .conflict_cnt_out (conflict_cnt_out),
        .debugen_in       (debugen_in)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of requests, check readies before the edge and the
    // registered write port just after it. Called at posedge+1.
    task automatic cyc(input string tag,
                       input logic v0, input logic [7:0] a0, input logic [31:0] d0,
                       input logic v1, input logic [7:0] a1, input logic [31:0] d1,
                       input logic r0e, input logic r1e,
                       input logic we, input logic [7:0] ae, input logic [31:0] de);
        src0_valid_in = v0; src0_addr_in = a0; src0_data_in = d0;
        src1_valid_in = v1; src1_addr_in = a1; src1_data_in = d1;
        #1;
        check({tag, ".rdy0"}, {31'd0, src0_ready_out}, {31'd0, r0e});
        check({tag, ".rdy1"}, {31'd0, src1_ready_out}, {31'd0, r1e});
        @(posedge clk); #1;
        check({tag, ".wr"}, {31'd0, write_out}, {31'd0, we});
        if (we) begin
            check({tag, ".waddr"}, {24'd0, write_addr_out}, {24'd0, ae});
            check({tag, ".wdata"}, write_data_out, de);
        end
    endtask

    initial begin
        reset = 1'b0; debugen_in = 1'b0;
        src0_valid_in = 1'b1; src0_addr_in = 8'd5; src0_data_in = 32'h1234;
        src1_valid_in = 1'b1; src1_addr_in = 8'd6; src1_data_in = 32'h5678;
        read_addr0_in = 8'd0; read_addr1_in = 8'd0;
        #1;
        check("rst.rdy0", {31'd0, src0_ready_out}, 32'd0);
        check("rst.rdy1", {31'd0, src1_ready_out}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst.wr",    {31'd0, write_out}, 32'd0);
        check("rst.waddr", {24'd0, write_addr_out}, 32'd0);
        check("rst.wdata", write_data_out, 32'd0);
        check("rst.cnt",   {16'd0, conflict_cnt_out}, 32'd0);
        src0_valid_in = 1'b0; src1_valid_in = 1'b0;
        reset = 1'b1;

        // Single source, then idle: address/data hold, write drops.
        cyc("single", 1, 8'd5, 32'h1234, 0, 8'd0, 32'h0, 1, 0, 1, 8'd5, 32'h1234);
        cyc("idle",   0, 8'd0, 32'h0,    0, 8'd0, 32'h0, 0, 0, 0, 8'd0, 32'h0);
        check("idle.hold_addr", {24'd0, write_addr_out}, 32'd5);
        check("idle.hold_data", write_data_out, 32'h1234);

        // Contention: src0,src0,src0,src1 repeating; conflict count 8.
        debugen_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i % 4 == 3)
                cyc("contend", 1, 8'd1, 32'h11, 1, 8'd2, 32'h22, 0, 1, 1, 8'd2, 32'h22);
            else
                cyc("contend", 1, 8'd1, 32'h11, 1, 8'd2, 32'h22, 1, 0, 1, 8'd1, 32'h11);
        end
        check("contend.cnt", {16'd0, conflict_cnt_out}, 32'd8);

        // Zero discard between contended cycles must not advance the starve counter.
        cyc("pre_zero",  1, 8'd1, 32'h11, 1, 8'd2, 32'h22,    1, 0, 1, 8'd1, 32'h11);
        cyc("zero",      1, 8'd3, 32'h33, 1, 8'd0, 32'hDEAD,  1, 1, 1, 8'd3, 32'h33);
        cyc("post_zero1",1, 8'd1, 32'h11, 1, 8'd2, 32'h22,    1, 0, 1, 8'd1, 32'h11);
        cyc("post_zero2",1, 8'd1, 32'h11, 1, 8'd2, 32'h22,    1, 0, 1, 8'd1, 32'h11);
        cyc("post_zero3",1, 8'd1, 32'h11, 1, 8'd2, 32'h22,    0, 1, 1, 8'd2, 32'h22);
        check("zero.cnt", {16'd0, conflict_cnt_out}, 32'd12);
        debugen_in = 1'b0;
        cyc("nodebug",   1, 8'd1, 32'h11, 1, 8'd2, 32'h22,    1, 0, 1, 8'd1, 32'h11);
        check("nodebug.cnt", {16'd0, conflict_cnt_out}, 32'd12);

        // Bypass after a src0 write to r7.
        cyc("bypass", 1, 8'd7, 32'hCAFE, 0, 8'd0, 32'h0, 1, 0, 1, 8'd7, 32'hCAFE);
        src0_valid_in = 1'b0;
        read_addr0_in = 8'd7; read_addr1_in = 8'd8;
        #1;
        check("bypass.hit0", {31'd0, bypass0_hit_out}, 32'd1);
        check("bypass.hit1", {31'd0, bypass1_hit_out}, 32'd0);
        check("bypass.data", bypass_data_out, 32'hCAFE);
        read_addr1_in = 8'd7;
        #1;
        check("bypass.hit1b", {31'd0, bypass1_hit_out}, 32'd1);
        @(posedge clk); #1;
        check("bypass.idle_hit0", {31'd0, bypass0_hit_out}, 32'd0);

        // Reset with a write pending and requests presented.
        cyc("pend", 1, 8'd9, 32'h99, 0, 8'd0, 32'h0, 1, 0, 1, 8'd9, 32'h99);
        reset = 1'b0;
        src0_valid_in = 1'b1; src0_addr_in = 8'd4; src0_data_in = 32'h44;
        src1_valid_in = 1'b1; src1_addr_in = 8'd6; src1_data_in = 32'h66;
        #1;
        check("midrst.rdy0", {31'd0, src0_ready_out}, 32'd0);
        check("midrst.rdy1", {31'd0, src1_ready_out}, 32'd0);
        @(posedge clk); #1;
        check("midrst.wr",    {31'd0, write_out}, 32'd0);
        check("midrst.waddr", {24'd0, write_addr_out}, 32'd0);
        check("midrst.wdata", write_data_out, 32'd0);
        check("midrst.cnt",   {16'd0, conflict_cnt_out}, 32'd0);
        check("midrst.hit0",  {31'd0, bypass0_hit_out}, 32'd0);
        reset = 1'b1; debugen_in = 1'b1;
        cyc("restart", 1, 8'd4, 32'h44, 1, 8'd6, 32'h66, 1, 0, 1, 8'd4, 32'h44);
        check("restart.cnt", {16'd0, conflict_cnt_out}, 32'd1);

        // Saturation of the conflict counter.
        repeat (70000) @(posedge clk);
        #1;
        check("sat.cnt", {16'd0, conflict_cnt_out}, 32'hFFFF);
        @(posedge clk); #1;
        check("sat.hold", {16'd0, conflict_cnt_out}, 32'hFFFF);

        src0_valid_in = 1'b0; src1_valid_in = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the single register-file write port between two writeback sources: src0 (ALU) and src1 (load unit).
- Arbitrates with fixed priority and starvation protection.
- Registers the winning write and drives it into the register file's write_addr/write/write_data inputs.
- Exposes bypass hits so the read stage can forward a write that is still landing.

Parameters:
DATA_WIDTH, 32, width of writeback data
ADDR_WIDTH, 8, width of register index
STARVE_LIMIT, 3, consecutive src1 losses before src1 is forced to win (1..15)
ZERO_REG_DISCARD, 1, when 1, writes to register index 0 are acknowledged but never issued

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-low reset
src0_valid_in  input  1  ALU writeback request
src0_addr_in  input  ADDR_WIDTH  ALU destination register
src0_data_in  input  DATA_WIDTH  ALU result
src0_ready_out  output  1  src0 request accepted this cycle
src1_valid_in  input  1  load writeback request
src1_addr_in  input  ADDR_WIDTH  load destination register
src1_data_in  input  DATA_WIDTH  load data
src1_ready_out  output  1  src1 request accepted this cycle
write_out  output  1  register-file write enable
write_addr_out  output  ADDR_WIDTH  register-file write index
write_data_out  output  DATA_WIDTH  register-file write data
read_addr0_in  input  ADDR_WIDTH  read port 0 index (same value fed to the register file)
read_addr1_in  input  ADDR_WIDTH  read port 1 index
bypass0_hit_out  output  1  read port 0 matches the write currently on write_*_out
bypass1_hit_out  output  1  read port 1 matches
bypass_data_out  output  DATA_WIDTH  equals write_data_out; valid when either hit is 1
conflict_cnt_out  output  16  saturating count of cycles where both sources requested non-zero writes
debugen_in  input  1  enables conflict_cnt_out counting

Behaviour:
- Reset: reset is synchronous and active-low. While reset==0 at a posedge, these registers clear:
  - write_out=0, write_addr_out=0, write_data_out=0
  - starve counter=0, conflict_cnt_out=0
- Ready outputs: combinational. Both are 0 while reset==0.
- Handshake: a request transfers when valid&ready in the same cycle. A source must hold valid/addr/data stable until ready is 1.
- Zero-address discard (ZERO_REG_DISCARD=1, addr==0):
  - The request gets ready=1 in the same cycle, independent of the other source.
  - It does not count as contention and does not change the starve counter.
- Arbitration among non-zero requests; "eligible" means valid and addr!=0:
  - Only one source eligible: that source wins.
  - Both eligible and starve counter < STARVE_LIMIT: src0 wins, and the starve counter increments.
  - Both eligible and starve counter == STARVE_LIMIT: src1 wins, and the starve counter clears.
  - Whenever src1 wins, the starve counter clears.
  - Cycle with no contention and no src1 win: the counter holds.
- Output stage, latency 1 cycle:
  - The winner's addr/data are registered into write_addr_out/write_data_out, with write_out=1 on the next cycle.
  - No winner: write_out=0 next cycle, and addr/data hold their previous values.
  - The register file is always ready, so there is no downstream backpressure and one write per cycle is sustained.
- Bypass:
  - bypass0_hit_out = write_out & (read_addr0_in==write_addr_out); bypass1_hit_out is the same with read_addr1_in.
  - Both are combinational from registered state and forced to 0 when write_addr_out==0 and ZERO_REG_DISCARD=1.
- conflict_cnt_out: increments when both sources are eligible and debugen_in=1. Saturates at 0xFFFF.
- Same-address collision, both eligible with the same addr: normal arbitration applies. The loser writes on a later cycle, so last-granted wins the final register value.
- Reset mid-transfer:
  - A grant presented in the same cycle that reset==0 is dropped, because ready is 0.
  - Any write held in the output register is lost, because write_out clears.

Decomposition:
- Shared package (Predef_pkg or a cpu package) holds:
  - wb_req_t struct {addr, data}
  - a constant REG_ZERO=0
  - the default widths
- One natural sub-module: wb_starve_counter, the saturating/clearing counter plus the force-src1 compare. Everything else stays flat.

Test Plan:
- Single source: src0 valid, addr=5, data=0x1234 with src1 idle -> src0_ready=1 that cycle; next cycle write_out=1, addr=5, data=0x1234.
- Contention with STARVE_LIMIT=3: both valid every cycle (src0 addr=1, src1 addr=2) -> grant order src0, src0, src0, src1, repeating; conflict_cnt_out=8 after 8 cycles with debugen_in=1.
- Zero discard: src1 addr=0, data=0xDEAD while src0 addr=3 is valid -> both ready same cycle; next cycle write_out=1 with addr=3 only, and the starve counter is unchanged.
- Bypass: after a src0 write to addr=7, data=0xCAFE, drive read_addr0_in=7 and read_addr1_in=8 -> bypass0_hit=1, bypass1_hit=0, bypass_data_out=0xCAFE.
- Reset mid-stream: write_out=1 pending and reset driven to 0 for one cycle -> both ready=0 that cycle; next cycle all outputs and conflict_cnt_out are 0, and arbitration restarts with src0 priority.
- Saturation: force 70000 contended cycles with debugen_in=1 -> conflict_cnt_out holds at 0xFFFF.
